// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider built around one carry_lookahead_adder
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst_n        asynchronous reset, active-low
//   i_start        request to divide, sampled only in IDLE
//   i_dividend     dividend, captured in the accepted start cycle
//   i_divisor      divisor, captured in the accepted start cycle
//   o_busy         high while in RUN
//   o_done         single-cycle pulse, results valid in that cycle
//   o_quotient     quotient, held until a new result is produced
//   o_remainder    remainder, held until a new result is produced
//   o_div_by_zero  set with o_done when the divisor was zero
//
// Build option: define DIV_SIGNED_EN for two's complement operands
// (magnitude division plus one SIGN cycle, latency bits+2).

module carry_lookahead_adder #(
    parameter int width = 9
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    input  logic             i_cin,
    output logic [width-1:0] o_sum,
    output logic             o_cout
);
    logic [width-1:0] w_g;
    logic [width-1:0] w_p;
    logic [width:0]   w_c;
    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < width; k++) begin
            w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
        end
    end
    assign o_sum  = w_p ^ w_c[width-1:0];
    assign o_cout = w_c[width];
endmodule

module seq_restoring_divider #(
    parameter int bits = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [bits-1:0] i_dividend,
    input  logic [bits-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_done,
    output logic [bits-1:0] o_quotient,
    output logic [bits-1:0] o_remainder,
    output logic            o_div_by_zero
);
    localparam int CW = $clog2(bits);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_SIGN} state_t;
`ifdef DIV_SIGNED_EN
    localparam state_t S_AFTER_RUN = S_SIGN;
`else
    localparam state_t S_AFTER_RUN = S_DONE;
`endif
    state_t          r_state, w_state_nx;
    logic [bits-1:0] r_q, r_r, r_d, r_quo, r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_dbz;
    logic            w_accept, w_zero, w_last, w_cout, w_nb;
    logic [bits:0]   w_rs, w_t;
    logic [bits-1:0] w_q_nx, w_r_nx, w_dvd, w_dvs, w_zq;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_zero   = (i_divisor == '0);
    assign w_last   = (r_cnt == CW'(bits - 1));
    assign w_rs     = {r_r, r_q[bits-1]};

    // trial subtraction R_shifted - D; cout is the no-borrow flag
    carry_lookahead_adder #(.width(bits + 1)) u_cla (
        .i_a   (w_rs),
        .i_b   (~{1'b0, r_d}),
        .i_cin (1'b1),
        .o_sum (w_t),
        .o_cout(w_cout)
    );

    // with no borrow the difference is below D, so its top bit is always clear
    assign w_nb   = w_cout & ~w_t[bits];
    assign w_r_nx = w_nb ? w_t[bits-1:0] : w_rs[bits-1:0];
    assign w_q_nx = {r_q[bits-2:0], w_nb};

`ifdef DIV_SIGNED_EN
    logic r_neg_q, r_neg_r;
    assign w_dvd = i_dividend[bits-1] ? -i_dividend : i_dividend;
    assign w_dvs = i_divisor[bits-1] ? -i_divisor : i_divisor;
    assign w_zq  = i_dividend[bits-1] ? bits'(1) : '1;
`else
    assign w_dvd = i_dividend;
    assign w_dvs = i_divisor;
    assign w_zq  = '1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = w_accept ? (w_zero ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:   w_state_nx = w_last ? S_AFTER_RUN : S_RUN;
            S_SIGN:  w_state_nx = S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_RUN);
        o_done = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_q   <= w_dvd;
                r_r   <= '0;
                r_d   <= w_dvs;
                r_cnt <= '0;
`ifdef DIV_SIGNED_EN
                r_neg_q <= i_dividend[bits-1] ^ i_divisor[bits-1];
                r_neg_r <= i_dividend[bits-1];
`endif
            end else if (r_state == S_RUN) begin
                r_q   <= w_q_nx;
                r_r   <= w_r_nx;
                r_cnt <= r_cnt + 1'b1;
            end
            // results are loaded on the edge entering DONE so they are valid with o_done
            if (w_accept && w_zero) begin
                r_quo <= w_zq;
                r_rem <= i_dividend;
                r_dbz <= 1'b1;
`ifdef DIV_SIGNED_EN
            end else if (r_state == S_SIGN) begin
                r_quo <= r_neg_q ? -r_q : r_q;
                r_rem <= r_neg_r ? -r_r : r_r;
                r_dbz <= 1'b0;
`else
            end else if (r_state == S_RUN && w_last) begin
                r_quo <= w_q_nx;
                r_rem <= w_r_nx;
                r_dbz <= 1'b0;
`endif
            end
        end
    end

    assign o_quotient    = r_quo;
    assign o_remainder   = r_rem;
    assign o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: vector table, corner sequences and random checks against an arithmetic model
module tb_seq_restoring_divider;
    logic       clk = 1'b0;
    logic       i_rst_n, i_start;
    logic [7:0] i_dividend, i_divisor;
    logic       o_busy, o_done, o_div_by_zero;
    logic [7:0] o_quotient, o_remainder;
    int n_tests = 0;
    int n_fail  = 0;

`ifdef DIV_SIGNED_EN
    localparam int LATN = 10;
`else
    localparam int LATN = 9;
`endif

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       dz;
        int         lat;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    seq_restoring_divider #(.bits(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a, b, q, r, input logic dz, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    function automatic void model(input logic [7:0] a, b, output logic [7:0] q, r, output logic dz, output int lat);
`ifdef DIV_SIGNED_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = (b == 8'd0);
        lat = dz ? 1 : 10;
        if (dz) begin
            q = (sa < 0) ? 8'd1 : 8'hFF;
            r = a;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80;
            r = 8'h00;
        end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
`else
        dz = (b == 8'd0);
        lat = dz ? 1 : 9;
        if (dz) begin
            q = 8'hFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    // launches one division and returns in the o_done cycle (or after the cycle bound)
    task automatic check_op(input string tag, input logic [7:0] a, b, eq, er, input logic edz, input int elat);
        int lat, busy;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_dividend = 8'($urandom);
        i_divisor  = 8'($urandom);
        lat  = 1;
        busy = 0;
        while (!o_done && lat < 40) begin
            busy += int'(o_busy);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, o_done, 1);
        chk({tag, "_q"}, o_quotient, eq);
        chk({tag, "_r"}, o_remainder, er);
        chk({tag, "_dz"}, o_div_by_zero, edz);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy"}, busy, edz ? 0 : 8);
    endtask

    initial begin
        logic [7:0] eq, er, a, b, gq, gr, pq;
        logic       edz;
        int         elat, nd, nb;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_dividend = 8'd0;
        i_divisor  = 8'd0;
`ifdef DIV_SIGNED_EN
        vt.push_back(mk(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 10));
        vt.push_back(mk(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 10));
        vt.push_back(mk(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 10));
        vt.push_back(mk(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1));
        vt.push_back(mk(8'hFB, 8'd0, 8'd1, 8'hFB, 1'b1, 1));
        vt.push_back(mk(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 10));
`else
        vt.push_back(mk(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9));
        vt.push_back(mk(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9));
        vt.push_back(mk(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9));
        vt.push_back(mk(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9));
        vt.push_back(mk(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1));
        vt.push_back(mk(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9));
        vt.push_back(mk(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9));
        vt.push_back(mk(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9));
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_q", o_quotient, 0);
        chk("rst_r", o_remainder, 0);
        chk("rst_dz", o_div_by_zero, 0);
        @(negedge clk) i_rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            check_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].lat);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse", i), o_done, 0);
        end
        pq = vt[vt.size()-1].q;

        // start pulse during RUN must be ignored
        i_dividend = 8'd100; i_divisor = 8'd9; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        i_dividend = 8'd10; i_divisor = 8'd3; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("ign_busy", o_busy, 1);
        chk("ign_hold_q", o_quotient, pq);
        nd = 0; gq = 8'd0; gr = 8'd0;
        for (int i = 0; i < 20; i++) begin
            if (o_done) begin
                nd++;
                gq = o_quotient;
                gr = o_remainder;
            end
            @(posedge clk); #1;
        end
        chk("ign_ndone", nd, 1);
        chk("ign_q", gq, 11);
        chk("ign_r", gr, 1);

        // start in the o_done cycle is not accepted
        check_op("dstart", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, LATN);
        i_dividend = 8'd20; i_divisor = 8'd4; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("dstart_busy", o_busy, 0);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            nb += int'(o_busy) + int'(o_done);
            @(posedge clk); #1;
        end
        chk("dstart_idle", nb, 0);
        chk("dstart_hold_q", o_quotient, 10);

        // reset in the 4th RUN cycle abandons the operation
        i_dividend = 8'd100; i_divisor = 8'd9; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        i_rst_n = 1'b0;
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_q", o_quotient, 0);
        chk("mrst_r", o_remainder, 0);
        chk("mrst_dz", o_div_by_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) i_rst_n = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            nd += int'(o_done);
            @(posedge clk); #1;
        end
        chk("mrst_nodone", nd, 0);
        check_op("mrst_9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, LATN);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            model(a, b, eq, er, edz, elat);
            check_op($sformatf("rnd%0d", i), a, b, eq, er, edz, elat);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
